alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Sits directly upstream of cv32e40p_alu and feeds it: buffers ALU requests from a valid/ready source, drives the ALU operand/control pins, and holds them stable across multicycle ops (div/rem, ALU ready_o low).
- Captures ALU result/comparison into a one-entry response register with valid/ready output.
- Generates the ALU ex_ready_i handshake.

Parameters:
- DEPTH, 4: request FIFO entries; power of two, >=2.
- CNT_W, $clog2(DEPTH)+1: occupancy counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_i  in  alu_req_t  operator, operand_a/b/c, vector_mode, bmask_a/b, imm_vec_ext, is_clpx, is_subrot, clpx_shift.
- flush_i  in  1  drop queued (not in-flight) requests.
- alu_req_o  out  alu_req_t  to ALU operator_i..clpx_shift_i.
- alu_enable_o  out  1  to ALU enable_i.
- alu_ex_ready_o  out  1  to ALU ex_ready_i.
- alu_result_i  in  32  from ALU result_o.
- alu_cmp_i  in  1  from ALU comparison_result_o.
- alu_ready_i  in  1  from ALU ready_o.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid&ready.
- rsp_result_o  out  32  captured result.
- rsp_cmp_o  out  1  captured comparison.
- count_o  out  CNT_W  FIFO occupancy.
- stall_cnt_o  out  32  cycles with alu_enable_o=1 and no completion; saturates at all-ones.

Behaviour:
- Reset (rst high, async): FIFO empty, FSM=IDLE, all outputs 0 (req_ready_o=0, alu_req_o=0, enable=0, rsp_valid_o=0, count_o=0, stall_cnt_o=0). First cycle after release: req_ready_o=1.
- req_ready_o = (count<DEPTH) & ~flush_i. Push and pop may occur in the same cycle; count unchanged. Push when full is impossible.
- alu_req_o = FIFO head when count>0, else all zeros. alu_enable_o = (count>0). The head is never modified while enabled.
- alu_ex_ready_o = ~rsp_valid_o | rsp_ready_i. This is the response slot free, or being freed this cycle.
- Completion: alu_enable_o & alu_ready_i & alu_ex_ready_o. On completion, in the same edge: pop head, load rsp_result_o/rsp_cmp_o, set rsp_valid_o=1.
- rsp_valid_o clears on rsp_ready_i with no completion in that cycle.
- FSM states:
  - IDLE: count=0. Goes to EXEC when count>0.
  - EXEC: head driven, alu_ready_i=0 (multicycle). Goes to HOLD when alu_ready_i=1 & ~alu_ex_ready_o. On completion, stays in EXEC if count_next>0, else IDLE.
  - HOLD: ALU result ready but response slot full. Operands held. Completes when alu_ex_ready_o rises. Next state follows the EXEC completion rule.
- Latency: request accepted at edge N appears on ALU in cycle N+1. A single-cycle op completes at edge N+1, so rsp_valid_o is high in cycle N+2. Throughput is 1 op/cycle with rsp_ready_i held high.
- flush_i removes all entries except the head when alu_enable_o=1; with an empty FIFO it has no effect. Flush does not abort the in-flight head and does not touch the response register.
  - Completion and flush in the same cycle: the head pops, count becomes 0.
- stall_cnt_o increments each cycle alu_enable_o=1 with no completion.
- Reset mid-operation (e.g. during a divide) returns everything to reset values. The ALU is reset on the same rst.

Decomposition:
- alu_issue_pkg holds:
  - alu_req_t packed struct, reusing cv32e40p_pkg::alu_opcode_e for the operator.
  - FSM state enum issue_state_e {IDLE, EXEC, HOLD}.
- One sub-module alu_issue_fifo (DEPTH, T=alu_req_t):
  - push/pop/flush_keep_head/count interface.
  - Pointers one bit wider than the index for full/empty. Wrap-around by pointer overflow.

Test Plan:
- Reset release, then ALU_ADD a=5 b=7 accepted at edge 0, rsp_ready=1 -> alu_enable_o=1 in cycle 1, rsp_valid_o=1 rsp_result_o=12 in cycle 2, count_o returns to 0.
- 4 back-to-back ALU_ADD (i+1) with rsp_ready=1 -> 4 consecutive responses 1..4 in order, no bubbles, stall_cnt_o=0.
- ALU_DIVU a=100 b=7 with ALU ready_o low 34 cycles -> alu_req_o stable all 34 cycles, rsp_result_o=14, stall_cnt_o=34.
- rsp_ready_i=0 and 6 requests pushed with DEPTH=4 -> first response held, FSM in HOLD, alu_ex_ready_o=0, count_o=4, req_ready_o=0. Release rsp_ready -> all drain in order.
- 3 requests queued, flush_i pulsed while head in EXEC -> head completes, count_o=0, no further responses. A request offered during the flush cycle is not accepted.
- rst asserted mid-divide -> all outputs 0 immediately (async). After release, a new ALU_SUB 9-4 returns 5.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue controller: the request bundle presented
// to cv32e40p_alu and the issue FSM state encoding.
package alu_issue_pkg;

  localparam int ALU_OP_WIDTH = 7;

  // Operator codes, bit-identical to cv32e40p_pkg::alu_opcode_e so the
  // request field wires straight onto the ALU operator_i pin.
  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_LTS  = 7'b0000000,
    ALU_LTU  = 7'b0000001,
    ALU_EQ   = 7'b0001100,
    ALU_NE   = 7'b0001101,
    ALU_AND  = 7'b0010101,
    ALU_ADD  = 7'b0011000,
    ALU_SUB  = 7'b0011001,
    ALU_OR   = 7'b0101110,
    ALU_XOR  = 7'b0101111,
    ALU_DIVU = 7'b0110000,
    ALU_DIV  = 7'b0110001,
    ALU_REMU = 7'b0110010,
    ALU_REM  = 7'b0110011
  } alu_opcode_e;

  // One ALU request: everything the ALU samples from operator_i to clpx_shift_i.
  typedef struct packed {
    alu_opcode_e opcode;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] operand_c;
    logic [1:0]  vector_mode;
    logic [4:0]  bmask_a;
    logic [4:0]  bmask_b;
    logic [1:0]  imm_vec_ext;
    logic        is_clpx;
    logic        is_subrot;
    logic [1:0]  clpx_shift;
  } alu_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } issue_state_e;

endpackage

// File: rtl/alu_issue_fifo.sv
// Request FIFO. Pointers carry one extra wrap bit so full and empty are
// distinguished without a separate counter; occupancy is their difference.
module alu_issue_fifo
  import alu_issue_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = alu_req_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  T                         i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush_keep_head,
  output T                         o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  T                 r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             w_empty;
  logic             w_flush;
  logic             w_wr_en;

  assign o_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (o_count == PTR_W'(DEPTH));
  assign o_head  = r_mem[r_rd_ptr[IDX_W-1:0]];
  // A flush on a non-empty FIFO discards everything behind the head, so a
  // push in that cycle is dropped as well.
  assign w_flush = i_flush_keep_head & ~w_empty;
  assign w_wr_en = i_push & ~w_flush;

  // Pointer update: flush collapses the write pointer onto the slot after the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_flush) begin
      r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop);
      r_wr_ptr <= r_rd_ptr + PTR_W'(1);
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Storage write; entries are data only and need no reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[IDX_W-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of cv32e40p_alu: queues requests, presents the
// head to the ALU until it completes, and captures results into a one-entry
// response register with valid/ready.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  alu_req_t          req_i,
  input  logic              flush_i,
  output alu_req_t          alu_req_o,
  output logic              alu_enable_o,
  output logic              alu_ex_ready_o,
  input  logic [31:0]       alu_result_i,
  input  logic              alu_cmp_i,
  input  logic              alu_ready_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_result_o,
  output logic              rsp_cmp_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [31:0]       stall_cnt_o
);

  issue_state_e     r_state;
  issue_state_e     w_state_nxt;
  alu_req_t         w_head;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_full;
  logic             w_push;
  logic             w_complete;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_result;
  logic             r_rsp_cmp;
  logic [31:0]      r_stall_cnt;

  alu_issue_fifo #(
    .DEPTH (DEPTH),
    .T     (alu_req_t)
  ) u_fifo (
    .clk               (clk),
    .rst               (rst),
    .i_push            (w_push),
    .i_push_data       (req_i),
    .i_pop             (w_complete),
    .i_flush_keep_head (flush_i & alu_enable_o),
    .o_head            (w_head),
    .o_count           (w_count),
    .o_full            (w_full)
  );

  // Handshake outputs are forced low while reset is held so every output
  // reads zero during reset.
  assign req_ready_o    = ~rst & ~w_full & ~flush_i;
  assign alu_ex_ready_o = ~rst & (~r_rsp_valid | rsp_ready_i);
  assign alu_enable_o   = (r_state != IDLE);
  assign alu_req_o      = alu_enable_o ? w_head : '0;
  assign w_push         = req_valid_i & req_ready_o;
  assign w_complete     = alu_enable_o & alu_ready_i & alu_ex_ready_o;

  assign count_o        = w_count;
  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_result_o   = r_rsp_result;
  assign rsp_cmp_o      = r_rsp_cmp;
  assign stall_cnt_o    = r_stall_cnt;

  // Occupancy after this edge; a flush leaves only the head, or nothing if it pops.
  always_comb begin
    w_count_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_complete);
    if (flush_i && alu_enable_o) begin
      w_count_nxt = w_complete ? '0 : CNT_W'(1);
    end
  end

  // Issue FSM next state: EXEC while waiting on the ALU, HOLD while the
  // result is ready but the response slot is still occupied.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_count_nxt != '0) w_state_nxt = EXEC;
      end
      EXEC, HOLD: begin
        if (w_complete) begin
          w_state_nxt = (w_count_nxt != '0) ? EXEC : IDLE;
        end else if (alu_ready_i && !alu_ex_ready_o) begin
          w_state_nxt = HOLD;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Response slot: load on completion, otherwise release when consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_cmp    <= 1'b0;
    end else if (w_complete) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_result <= alu_result_i;
      r_rsp_cmp    <= alu_cmp_i;
    end else if (rsp_ready_i) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  // Saturating count of enabled cycles that did not complete.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (alu_enable_o && !w_complete && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU plus a queue-based reference
// model of the issue/response protocol.
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  alu_req_t         req_i = '0;
  logic             flush_i = 1'b0;
  alu_req_t         alu_req_o;
  logic             alu_enable_o;
  logic             alu_ex_ready_o;
  logic [31:0]      alu_result_i = '0;
  logic             alu_cmp_i = 1'b0;
  logic             alu_ready_i = 1'b0;
  logic             rsp_valid_o;
  logic             rsp_ready_i = 1'b0;
  logic [31:0]      rsp_result_o;
  logic             rsp_cmp_o;
  logic [CNT_W-1:0] count_o;
  logic [31:0]      stall_cnt_o;

  int n_vec = 0;
  int n_err = 0;
  int req_lat = 0;

  // Reference model state
  alu_req_t    m_q[$];
  int          m_lat[$];
  int          m_hold;
  logic        m_rsp_v;
  logic [31:0] m_res;
  logic        m_cmp;
  logic [31:0] m_stall;
  bit          m_push;

  alu_opcode_e ops [7] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_DIVU, ALU_REMU, ALU_EQ};

  alu_issue_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_i          (req_i),
    .flush_i        (flush_i),
    .alu_req_o      (alu_req_o),
    .alu_enable_o   (alu_enable_o),
    .alu_ex_ready_o (alu_ex_ready_o),
    .alu_result_i   (alu_result_i),
    .alu_cmp_i      (alu_cmp_i),
    .alu_ready_i    (alu_ready_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_result_o   (rsp_result_o),
    .rsp_cmp_o      (rsp_cmp_o),
    .count_o        (count_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(alu_req_t r);
    case (r.opcode)
      ALU_ADD:  return r.operand_a + r.operand_b;
      ALU_SUB:  return r.operand_a - r.operand_b;
      ALU_AND:  return r.operand_a & r.operand_b;
      ALU_XOR:  return r.operand_a ^ r.operand_b;
      ALU_DIVU: return (r.operand_b == 0) ? 32'hFFFF_FFFF : r.operand_a / r.operand_b;
      ALU_REMU: return (r.operand_b == 0) ? r.operand_a : r.operand_a % r.operand_b;
      ALU_EQ:   return {31'd0, r.operand_a == r.operand_b};
      default:  return 32'd0;
    endcase
  endfunction

  function automatic bit is_div(alu_req_t r);
    return (r.opcode == ALU_DIVU) || (r.opcode == ALU_REMU);
  endfunction

  function automatic alu_req_t mk(alu_opcode_e op, logic [31:0] a, logic [31:0] b);
    alu_req_t r;
    r = '0;
    r.opcode = op;
    r.operand_a = a;
    r.operand_b = b;
    return r;
  endfunction

  function automatic alu_req_t rand_req();
    alu_req_t r;
    r = mk(ops[$urandom_range(0, 6)], 32'($urandom_range(0, 1000)), 32'($urandom_range(0, 40)));
    r.operand_c   = $urandom;
    r.vector_mode = 2'($urandom);
    r.bmask_a     = 5'($urandom);
    r.bmask_b     = 5'($urandom);
    r.imm_vec_ext = 2'($urandom);
    r.is_clpx     = 1'($urandom);
    r.is_subrot   = 1'($urandom);
    r.clpx_shift  = 2'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_lat.delete();
    m_hold  = 0;
    m_rsp_v = 1'b0;
    m_res   = '0;
    m_cmp   = 1'b0;
    m_stall = '0;
    m_push  = 1'b0;
  endtask

  // Behavioural ALU: multicycle ops keep ready_o low for their latency.
  task automatic drive_alu();
    alu_ready_i  = (m_q.size() > 0) && (m_hold >= m_lat[0]);
    alu_result_i = alu_fn(alu_req_o);
    alu_cmp_i    = (alu_req_o.operand_a == alu_req_o.operand_b);
  endtask

  // Advance the reference model by one clock using the current inputs.
  task automatic step();
    bit en, rdy, exr, compl, push;
    alu_req_t h;
    int l;
    en    = (m_q.size() > 0);
    rdy   = en && (m_hold >= m_lat[0]);
    exr   = !m_rsp_v || rsp_ready_i;
    compl = en && rdy && exr;
    push  = req_valid_i && (m_q.size() < DEPTH) && !flush_i;
    if (en && !compl && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (compl) begin
      m_rsp_v = 1'b1;
      m_res   = alu_fn(m_q[0]);
      m_cmp   = (m_q[0].operand_a == m_q[0].operand_b);
      void'(m_q.pop_front());
      void'(m_lat.pop_front());
      m_hold = 0;
    end else begin
      if (rsp_ready_i) m_rsp_v = 1'b0;
      if (en) m_hold++;
    end
    if (flush_i && en) begin
      if (compl) begin
        m_q.delete();
        m_lat.delete();
      end else begin
        h = m_q[0];
        l = m_lat[0];
        m_q.delete();
        m_lat.delete();
        m_q.push_back(h);
        m_lat.push_back(l);
      end
    end
    if (push) begin
      m_q.push_back(req_i);
      m_lat.push_back(is_div(req_i) ? req_lat : 0);
    end
    m_push = push;
    @(posedge clk);
    @(negedge clk);
    drive_alu();
  endtask

  task automatic idle(int n);
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive_alu();
    n_vec++; if (req_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_req_ready got %0b want 0", req_ready_o); end
    n_vec++; if (alu_enable_o !== 1'b0) begin n_err++; $display("FAIL reset_enable got %0b want 0", alu_enable_o); end
    n_vec++; if (alu_req_o !== '0) begin n_err++; $display("FAIL reset_alu_req got %0h want 0", alu_req_o); end
    n_vec++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid_o); end
    n_vec++; if (count_o !== '0) begin n_err++; $display("FAIL reset_count got %0d want 0", count_o); end
    n_vec++; if (stall_cnt_o !== '0) begin n_err++; $display("FAIL reset_stall got %0d want 0", stall_cnt_o); end
    rst = 1'b0;
    #1;
    n_vec++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL release_req_ready got %0b want 1", req_ready_o); end
  endtask

  task automatic test_single_add();
    req_i = mk(ALU_ADD, 32'd5, 32'd7);
    req_lat = 0;
    req_valid_i = 1'b1;
    rsp_ready_i = 1'b1;
    #1;
    n_vec++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL add_accept got %0b want 1", req_ready_o); end
    step();
    req_valid_i = 1'b0;
    n_vec++; if (alu_enable_o !== 1'b1) begin n_err++; $display("FAIL add_enable got %0b want 1", alu_enable_o); end
    n_vec++; if (alu_req_o !== mk(ALU_ADD, 32'd5, 32'd7)) begin n_err++; $display("FAIL add_operands got %0h want a=5 b=7", alu_req_o); end
    step();
    n_vec++; if (rsp_valid_o !== 1'b1) begin n_err++; $display("FAIL add_rsp_valid got %0b want 1", rsp_valid_o); end
    n_vec++; if (rsp_result_o !== 32'd12) begin n_err++; $display("FAIL add_result got %0d want 12", rsp_result_o); end
    n_vec++; if (count_o !== '0) begin n_err++; $display("FAIL add_count got %0d want 0", count_o); end
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic [31:0] s0;
    s0 = m_stall;
    rsp_ready_i = 1'b1;
    req_lat = 0;
    for (int k = 0; k < 6; k++) begin
      req_valid_i = (k < 4);
      req_i = mk(ALU_ADD, 32'(k), 32'd1);
      step();
      if (k >= 1 && k <= 4) begin
        n_vec++; if (rsp_valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_valid_%0d got %0b want 1", k, rsp_valid_o); end
        n_vec++; if (rsp_result_o !== 32'(k)) begin n_err++; $display("FAIL b2b_result_%0d got %0d want %0d", k, rsp_result_o, k); end
      end
    end
    n_vec++; if (stall_cnt_o !== s0) begin n_err++; $display("FAIL b2b_stall got %0d want %0d", stall_cnt_o, s0); end
    idle(3);
  endtask

  task automatic test_multicycle_div();
    alu_req_t d;
    logic [31:0] s0;
    s0 = m_stall;
    d = mk(ALU_DIVU, 32'd100, 32'd7);
    d.operand_c = 32'hCAFE_0001;
    d.bmask_a = 5'd9;
    req_i = d;
    req_lat = 34;
    req_valid_i = 1'b1;
    rsp_ready_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    for (int i = 0; i < 34; i++) begin
      n_vec++; if (alu_req_o !== d || alu_enable_o !== 1'b1) begin n_err++; $display("FAIL div_hold_%0d got %0h en=%0b want %0h en=1", i, alu_req_o, alu_enable_o, d); end
      step();
    end
    step();
    n_vec++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'd14) begin n_err++; $display("FAIL div_result got v=%0b %0d want v=1 14", rsp_valid_o, rsp_result_o); end
    n_vec++; if (stall_cnt_o !== s0 + 32'd34) begin n_err++; $display("FAIL div_stall got %0d want %0d", stall_cnt_o, s0 + 32'd34); end
    idle(3);
  endtask

  task automatic test_backpressure();
    int idx, k;
    idx = 0;
    req_lat = 0;
    rsp_ready_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      req_valid_i = (idx < 6);
      req_i = mk(ALU_ADD, 32'(10 * (idx + 1)), 32'(idx + 1));
      step();
      if (m_push) idx++;
    end
    #1;
    n_vec++; if (count_o !== 3'd4) begin n_err++; $display("FAIL bp_count got %0d want 4", count_o); end
    n_vec++; if (req_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_req_ready got %0b want 0", req_ready_o); end
    n_vec++; if (alu_ex_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ex_ready got %0b want 0", alu_ex_ready_o); end
    n_vec++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'd11) begin n_err++; $display("FAIL bp_held_rsp got v=%0b %0d want v=1 11", rsp_valid_o, rsp_result_o); end
    n_vec++; if (alu_enable_o !== 1'b1 || alu_req_o.operand_a !== 32'd20) begin n_err++; $display("FAIL bp_head_held got en=%0b a=%0d want en=1 a=20", alu_enable_o, alu_req_o.operand_a); end
    rsp_ready_i = 1'b1;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      req_valid_i = (idx < 6);
      req_i = mk(ALU_ADD, 32'(10 * (idx + 1)), 32'(idx + 1));
      #1;
      if (rsp_valid_o) begin
        n_vec++; if (rsp_result_o !== 32'(11 * (k + 1))) begin n_err++; $display("FAIL bp_drain_%0d got %0d want %0d", k, rsp_result_o, 11 * (k + 1)); end
        k++;
      end
      step();
      if (m_push) idx++;
    end
    n_vec++; if (k !== 6) begin n_err++; $display("FAIL bp_drain_count got %0d want 6", k); end
    idle(3);
  endtask

  task automatic test_flush();
    int nrsp;
    logic [31:0] first;
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1;
    req_i = mk(ALU_DIVU, 32'd50, 32'd5); req_lat = 6; step();
    req_i = mk(ALU_ADD, 32'd1, 32'd1); req_lat = 0; step();
    req_i = mk(ALU_ADD, 32'd2, 32'd2); step();
    n_vec++; if (count_o !== 3'd3) begin n_err++; $display("FAIL flush_pre_count got %0d want 3", count_o); end
    flush_i = 1'b1;
    req_i = mk(ALU_ADD, 32'd7, 32'd7);
    #1;
    n_vec++; if (req_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_req_ready got %0b want 0", req_ready_o); end
    step();
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    n_vec++; if (count_o !== 3'd1 || alu_enable_o !== 1'b1) begin n_err++; $display("FAIL flush_keep_head got cnt=%0d en=%0b want cnt=1 en=1", count_o, alu_enable_o); end
    nrsp = 0;
    first = '0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (rsp_valid_o) begin
        if (nrsp == 0) first = rsp_result_o;
        nrsp++;
      end
    end
    n_vec++; if (nrsp !== 1) begin n_err++; $display("FAIL flush_rsp_count got %0d want 1", nrsp); end
    n_vec++; if (first !== 32'd10) begin n_err++; $display("FAIL flush_head_result got %0d want 10", first); end
    n_vec++; if (count_o !== '0) begin n_err++; $display("FAIL flush_post_count got %0d want 0", count_o); end
  endtask

  task automatic test_random();
    alu_req_t exp_req;
    for (int c = 0; c < 400; c++) begin
      req_valid_i = ($urandom_range(0, 9) < 7);
      req_i       = rand_req();
      req_lat     = $urandom_range(1, 6);
      rsp_ready_i = ($urandom_range(0, 9) < 6);
      flush_i     = ($urandom_range(0, 19) == 0);
      #1;
      exp_req = '0;
      if (m_q.size() > 0) exp_req = m_q[0];
      n_vec++; if (count_o !== CNT_W'(m_q.size())) begin n_err++; $display("FAIL rnd_count c%0d got %0d want %0d", c, count_o, m_q.size()); end
      n_vec++; if (alu_enable_o !== (m_q.size() > 0)) begin n_err++; $display("FAIL rnd_enable c%0d got %0b", c, alu_enable_o); end
      n_vec++; if (alu_req_o !== exp_req) begin n_err++; $display("FAIL rnd_alu_req c%0d got %0h want %0h", c, alu_req_o, exp_req); end
      n_vec++; if (req_ready_o !== ((m_q.size() < DEPTH) && !flush_i)) begin n_err++; $display("FAIL rnd_req_ready c%0d got %0b", c, req_ready_o); end
      n_vec++; if (alu_ex_ready_o !== (!m_rsp_v || rsp_ready_i)) begin n_err++; $display("FAIL rnd_ex_ready c%0d got %0b", c, alu_ex_ready_o); end
      n_vec++; if (rsp_valid_o !== m_rsp_v) begin n_err++; $display("FAIL rnd_rsp_valid c%0d got %0b want %0b", c, rsp_valid_o, m_rsp_v); end
      n_vec++; if ({rsp_result_o, rsp_cmp_o} !== {m_res, m_cmp}) begin n_err++; $display("FAIL rnd_rsp_data c%0d got %0h/%0b want %0h/%0b", c, rsp_result_o, rsp_cmp_o, m_res, m_cmp); end
      n_vec++; if (stall_cnt_o !== m_stall) begin n_err++; $display("FAIL rnd_stall c%0d got %0d want %0d", c, stall_cnt_o, m_stall); end
      step();
    end
    idle(40);
  endtask

  task automatic test_reset_mid_div();
    bit seen;
    rsp_ready_i = 1'b1;
    req_i = mk(ALU_DIVU, 32'd1000, 32'd3);
    req_lat = 34;
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    repeat (10) step();
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (req_ready_o !== 1'b0 || alu_enable_o !== 1'b0 || alu_req_o !== '0) begin n_err++; $display("FAIL midrst_issue got rdy=%0b en=%0b req=%0h want 0", req_ready_o, alu_enable_o, alu_req_o); end
    n_vec++; if (rsp_valid_o !== 1'b0 || rsp_result_o !== '0 || count_o !== '0 || stall_cnt_o !== '0) begin n_err++; $display("FAIL midrst_state got v=%0b res=%0d cnt=%0d stall=%0d want 0", rsp_valid_o, rsp_result_o, count_o, stall_cnt_o); end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_alu();
    req_i = mk(ALU_SUB, 32'd9, 32'd4);
    req_lat = 0;
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (rsp_valid_o) begin
        seen = 1'b1;
        n_vec++; if (rsp_result_o !== 32'd5) begin n_err++; $display("FAIL midrst_sub got %0d want 5", rsp_result_o); end
      end
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL midrst_sub_timeout got no response want one"); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_add();
    test_back_to_back();
    test_multicycle_div();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
